lsu_mem_ctrl: RTL



---
 rtl/lsu_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store controller in the MEM stage, sitting directly in front of a
//   byte-addressable data memory that only performs full 32-bit writes.
//   Loads are sign- or zero-extended. SB/SH are done as read-modify-write.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid        request present
//   req_ready        controller can accept a request (IDLE only)
//   req_we           1 = store, 0 = load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned     zero-extend load (LBU/LHU); ignored for word
//   req_addr         byte address
//   req_wdata        store data (low bytes used for SB/SH)
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data, held until the next load completes,
//                    0 after a store or an error
//   resp_err         request rejected (illegal size / trapped misalignment)
//   mem_rd, mem_wr   memory read / write enables (never both)
//   mem_cs_n         memory chip select, active low
//   mem_addr         memory byte address
//   mem_wdata        memory write data
//   mem_rdata        memory read data, valid in the same cycle as rd && ~cs_n
//
// Handshake
//   A request transfers on a rising edge where req_valid && req_ready. The
//   request fields are latched on that edge and need not be held afterwards.
//   resp_valid is a single-cycle pulse; there is no back-pressure on the
//   response. req_ready is low from the accept edge until the cycle after
//   the response pulse.
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, a half access with addr[0]!=0 or a
//                         word access with addr[1:0]!=0 is rejected with
//                         resp_err and no memory cycle. When undefined the
//                         access proceeds at the raw byte address.
//
// The FSM state is kept in 'state' so checkers can bind to it directly.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              mem_cs_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_BAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WRITE  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t state;
   state_t state_d;

   // Latched request
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic              err_q;

   // Read-modify-write merge buffer and held load result
   logic [XLEN-1:0]   merge_q;
   logic [XLEN-1:0]   rdata_q;

   logic              accept;
   logic              misalign;
   logic              req_err;
   logic [XLEN-1:0]   load_ext;
   logic [XLEN-1:0]   merge_d;

   assign accept = req_valid && (state == S_IDLE);

   // -------------------------------------------------------------------------
   // Request classification (evaluated only on the accept cycle)
   // -------------------------------------------------------------------------
`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      if (req_size == SZ_H && req_addr[0] != 1'b0) begin
         misalign = 1'b1;
      end
      if (req_size == SZ_W && req_addr[1:0] != 2'b00) begin
         misalign = 1'b1;
      end
   end
`else
   // Memory supports unaligned byte lanes, so misaligned accesses simply
   // proceed at the raw byte address.
   assign misalign = 1'b0;
`endif

   assign req_err = (req_size == SZ_BAD) || misalign;

   // -------------------------------------------------------------------------
   // Load extension and RMW merge, both from the live memory read data
   // -------------------------------------------------------------------------
   always_comb begin
      load_ext = mem_rdata;
      case (size_q)
         SZ_B: load_ext = {{(XLEN-8){~uns_q & mem_rdata[7]}}, mem_rdata[7:0]};
         SZ_H: load_ext = {{(XLEN-16){~uns_q & mem_rdata[15]}}, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      merge_d      = mem_rdata;
      merge_d[7:0] = wdata_q[7:0];
      if (size_q == SZ_H) begin
         merge_d[15:8] = wdata_q[15:8];
      end
   end

   // -------------------------------------------------------------------------
   // State register and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         merge_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_d;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  err_q   <= req_err;
                  // Stores and rejected requests report zero read data;
                  // a good load keeps the old value until it captures.
                  if (req_we || req_err) begin
                     rdata_q <= '0;
                  end
               end
            end
            S_ACCESS: begin
               if (!we_q) begin
                  rdata_q <= load_ext;
               end else if (size_q != SZ_W) begin
                  merge_q <= merge_d;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Next state and outputs. Memory outputs depend only on the state and the
   // latched request, never on the live req_* inputs.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_cs_n   = 1'b1;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = req_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_cs_n = 1'b0;
            mem_addr = addr_q;
            if (we_q && size_q == SZ_W) begin
               mem_wr    = 1'b1;
               mem_wdata = wdata_q;
               state_d   = S_RESP;
            end else begin
               // Loads, and the read half of SB/SH
               mem_rd  = 1'b1;
               state_d = we_q ? S_WRITE : S_RESP;
            end
         end
         S_WRITE: begin
            mem_cs_n  = 1'b0;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = merge_q;
            state_d   = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A reset arriving mid-access aborts it: the memory strobe for the
      // current cycle is suppressed so a pending RMW write is never issued,
      // and no response is reported.
      if (rst) begin
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         mem_cs_n   = 1'b1;
         mem_addr   = '0;
         mem_wdata  = '0;
         resp_valid = 1'b0;
         resp_err   = 1'b0;
      end
   end

   assign resp_rdata = rdata_q;

endmodule
